pi_cmd_queue: RTL and testbench



---
 rtl/pi_cmd_queue_if.sv | 43 ++++
 rtl/pi_cmd_queue.sv | 193 +++++++++++++++++++
 tb/tb_pi_cmd_queue.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pi_cmd_queue_if.sv
// pi_cmd_queue_if
// Bundles the Pi register-write strobe, the bus-engine command handshake, the
// bus-engine response and the status outputs of the command queue.
//   wr_stb/wr_reg/wr_data  : Pi register write (one-cycle strobe)
//   cmd_*                  : head command towards the 68k bus-cycle engine
//   rsp_valid/rsp_data     : completion pulse and read data from the engine
//   rd_data/busy/overflow  : results and status towards the Pi side
// Modports: slave = the queue itself, master = its environment.
interface pi_cmd_queue_if #(
    parameter int AW = 24
);
    logic          wr_stb;
    logic [1:0]    wr_reg;
    logic [15:0]   wr_data;

    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [15:0]   cmd_data;
    logic          cmd_rw;
    logic [2:0]    cmd_fc;
    logic          cmd_uds_n;
    logic          cmd_lds_n;

    logic          rsp_valid;
    logic [15:0]   rsp_data;

    logic [15:0]   rd_data;
    logic          busy;
    logic          overflow;

    modport slave (
        input  wr_stb, wr_reg, wr_data, cmd_ready, rsp_valid, rsp_data,
        output cmd_valid, cmd_addr, cmd_data, cmd_rw, cmd_fc, cmd_uds_n, cmd_lds_n,
        output rd_data, busy, overflow
    );

    modport master (
        output wr_stb, wr_reg, wr_data, cmd_ready, rsp_valid, rsp_data,
        input  cmd_valid, cmd_addr, cmd_data, cmd_rw, cmd_fc, cmd_uds_n, cmd_lds_n,
        input  rd_data, busy, overflow
    );
endinterface

// File: rtl/pi_cmd_queue.sv
// pi_cmd_queue
// Assembles Pi DATA / ADDR_LO / ADDR_HI register writes into 68k bus commands,
// buffers them in a small FIFO and hands them to the bus-cycle engine one at a
// time. Captures read results and produces the transaction-busy flag.
//
// Ports:
//   PI_CLK   : system clock, all logic on the rising edge
//   RESET_n  : asynchronous active-low reset
//   bus      : pi_cmd_queue_if.slave (register writes, command handshake,
//              response, rd_data / busy / overflow)
//
// Build option PI_CMD_POSTED_WR_EN:
//   defined   - writes are posted, the full DEPTH is usable and busy reflects
//               pending reads or a full queue.
//   undefined - one transaction at a time: the slot stays occupied until the
//               response of its bus cycle, and busy covers that whole window.
//
// Command handshake: the head entry transfers when cmd_valid && cmd_ready are
// both high on a rising edge. cmd_valid and all cmd_* fields come straight from
// registers, stay stable while cmd_valid is high, and cmd_valid only drops by a
// transfer or reset. After a transfer cmd_valid stays low until rsp_valid
// reports completion of that bus cycle.
module pi_cmd_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 24
) (
    input  logic          PI_CLK,
    input  logic          RESET_n,
    pi_cmd_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = 1;

    localparam logic [1:0] REG_DATA    = 2'd0;
    localparam logic [1:0] REG_ADDR_LO = 2'd1;
    localparam logic [1:0] REG_ADDR_HI = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [15:0]   data;
        logic          rw;
        logic [2:0]    fc;
        logic          uds_n;
        logic          lds_n;
    } entry_t;

    // Idle head value: no strobes asserted, read direction.
    localparam entry_t HEAD_RESET = '{addr: '0, data: '0, rw: 1'b1, fc: '0,
                                      uds_n: 1'b1, lds_n: 1'b1};

    logic [15:0]   stg_addr;
    logic [15:0]   stg_data;
    logic          stg_a0;

    entry_t        mem [DEPTH];
    logic [PW:0]   wr_ptr;
    logic [PW:0]   rd_ptr;

    logic          cmd_valid_q;
    entry_t        head_q;
    logic          outstanding;
    logic          out_rw;
    logic [PW:0]   rd_pending;
    logic [15:0]   rd_data_q;
    logic          overflow_q;

    logic          ptr_eq;
    logic          empty;
    logic          full;
    logic          commit;
    logic          push;
    logic          pop;
    logic          rsp_take;
    entry_t        new_entry;

    // wr_data[14:13] carry nothing for this block.
    logic          unused_wr_bits;
    assign unused_wr_bits = &{1'b0, bus.wr_data[14:13]};

    assign ptr_eq = (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign empty  = ptr_eq && (wr_ptr[PW] == rd_ptr[PW]);

`ifdef PI_CMD_POSTED_WR_EN
    assign full   = ptr_eq && (wr_ptr[PW] != rd_ptr[PW]);
`else
    // Single-transaction mode: the slot is busy from commit until its response.
    assign full   = !empty || outstanding;
`endif

    assign commit   = bus.wr_stb && (bus.wr_reg == REG_ADDR_HI);
    assign push     = commit && !full;
    assign pop      = cmd_valid_q && bus.cmd_ready;
    assign rsp_take = bus.rsp_valid && outstanding;

    // Byte accesses pick one lane from address bit 0; word accesses use both.
    always_comb begin
        new_entry       = '0;
        new_entry.addr  = AW'({bus.wr_data[7:0], stg_addr});
        new_entry.data  = stg_data;
        new_entry.rw    = bus.wr_data[9];
        new_entry.fc    = bus.wr_data[12:10];
        new_entry.uds_n = bus.wr_data[8] ? stg_a0  : 1'b0;
        new_entry.lds_n = bus.wr_data[8] ? !stg_a0 : 1'b0;
    end

    // Storage needs no reset: slots are only read between push and pop.
    always_ff @(posedge PI_CLK) begin
        if (push) begin
            mem[wr_ptr[PW-1:0]] <= new_entry;
        end
    end

    always_ff @(posedge PI_CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            stg_addr    <= '0;
            stg_data    <= '0;
            stg_a0      <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            cmd_valid_q <= 1'b0;
            head_q      <= HEAD_RESET;
            outstanding <= 1'b0;
            out_rw      <= 1'b0;
            rd_pending  <= '0;
            rd_data_q   <= '0;
            overflow_q  <= 1'b0;
        end else begin
            if (bus.wr_stb) begin
                case (bus.wr_reg)
                    REG_DATA:    stg_data <= bus.wr_data;
                    REG_ADDR_LO: begin
                        stg_addr <= bus.wr_data;
                        stg_a0   <= bus.wr_data[0];
                    end
                    REG_STATUS:  if (bus.wr_data[15]) overflow_q <= 1'b0;
                    default:     ;
                endcase
            end

            if (commit && full) begin
                overflow_q <= 1'b1;
            end

            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end

            // The head register reloads only when it is empty, so its fields
            // never move under an asserted cmd_valid.
            if (pop) begin
                rd_ptr      <= rd_ptr + PTR_ONE;
                cmd_valid_q <= 1'b0;
                outstanding <= 1'b1;
                out_rw      <= head_q.rw;
            end else begin
                cmd_valid_q <= !empty && !outstanding;
                if (!cmd_valid_q && !empty && !outstanding) begin
                    head_q <= mem[rd_ptr[PW-1:0]];
                end
            end

            if (rsp_take) begin
                outstanding <= 1'b0;
                if (out_rw) begin
                    rd_data_q <= bus.rsp_data;
                end
            end

            case ({push && new_entry.rw, rsp_take && out_rw})
                2'b10:   rd_pending <= rd_pending + PTR_ONE;
                2'b01:   rd_pending <= rd_pending - PTR_ONE;
                default: ;
            endcase
        end
    end

    assign bus.cmd_valid = cmd_valid_q && !outstanding;
    assign bus.cmd_addr  = head_q.addr;
    assign bus.cmd_data  = head_q.data;
    assign bus.cmd_rw    = head_q.rw;
    assign bus.cmd_fc    = head_q.fc;
    assign bus.cmd_uds_n = head_q.uds_n;
    assign bus.cmd_lds_n = head_q.lds_n;
    assign bus.rd_data   = rd_data_q;
    assign bus.overflow  = overflow_q;

`ifdef PI_CMD_POSTED_WR_EN
    assign bus.busy = (rd_pending != '0) || full;
`else
    assign bus.busy = !empty || outstanding;
`endif
endmodule

// File: tb/tb_pi_cmd_queue.sv
module tb_pi_cmd_queue;
    localparam int DEPTH = 4;
    localparam int AW    = 24;

`ifdef PI_CMD_POSTED_WR_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif
    localparam int CAP = POSTED ? DEPTH : 1;

    localparam bit [1:0] R_DATA = 2'd0, R_LO = 2'd1, R_HI = 2'd2, R_ST = 2'd3;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_err    = 0;

    pi_cmd_queue_if #(.AW(AW)) bus ();

    pi_cmd_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .PI_CLK  (clk),
        .RESET_n (rst_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model (transaction level) ----------------
    typedef struct packed {
        logic [23:0] addr;
        logic [15:0] data;
        logic        rw;
        logic [2:0]  fc;
        logic        uds_n;
        logic        lds_n;
    } ent_t;

    ent_t        m_q[$];
    ent_t        m_head;
    bit          m_valid, m_out, m_out_rd, m_ovf;
    int          m_pend;
    logic [15:0] m_rd, m_sdata, m_saddr;

    task automatic model_reset();
        m_q.delete();
        m_head   = '{addr: 24'h0, data: 16'h0, rw: 1'b1, fc: 3'h0, uds_n: 1'b1, lds_n: 1'b1};
        m_valid  = 0;
        m_out    = 0;
        m_out_rd = 0;
        m_ovf    = 0;
        m_pend   = 0;
        m_rd     = 16'h0;
        m_sdata  = 16'h0;
        m_saddr  = 16'h0;
    endtask

    // One rising edge of the queue as seen from outside.
    task automatic model_edge(input bit stb, input bit [1:0] rg, input bit [15:0] wd,
                              input bit rdy, input bit rsp, input bit [15:0] rdat);
        bit   pop, out_pre, have_pre, full_pre;
        ent_t e;
        pop      = m_valid && rdy;
        out_pre  = m_out;
        have_pre = (m_q.size() != 0);
        full_pre = POSTED ? (m_q.size() == DEPTH) : (have_pre || out_pre);

        if (!m_valid && have_pre && !out_pre) m_head = m_q[0];
        m_valid = have_pre && !out_pre && !pop;

        if (pop) begin
            e        = m_q.pop_front();
            m_out    = 1;
            m_out_rd = e.rw;
        end
        if (rsp && out_pre) begin
            m_out = 0;
            if (m_out_rd) begin
                m_pend--;
                m_rd = rdat;
            end
        end
        if (stb) begin
            if (rg == R_DATA) m_sdata = wd;
            if (rg == R_LO)   m_saddr = wd;
            if (rg == R_ST && wd[15]) m_ovf = 0;
            if (rg == R_HI) begin
                if (full_pre) m_ovf = 1;
                else begin
                    e.addr = {wd[7:0], m_saddr};
                    e.data = m_sdata;
                    e.rw   = wd[9];
                    e.fc   = wd[12:10];
                    // 68k lanes: even byte on UDS, odd byte on LDS, word on both.
                    if (!wd[8]) begin
                        e.uds_n = 0; e.lds_n = 0;
                    end else if (m_saddr[0]) begin
                        e.uds_n = 1; e.lds_n = 0;
                    end else begin
                        e.uds_n = 0; e.lds_n = 1;
                    end
                    m_q.push_back(e);
                    if (e.rw) m_pend++;
                end
            end
        end
    endtask

    function automatic bit model_busy();
        return POSTED ? (m_pend != 0 || m_q.size() == DEPTH) : (m_q.size() != 0 || m_out);
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".cmd_valid"}, bus.cmd_valid, m_valid);
        chk({tag, ".busy"}, bus.busy, model_busy());
        chk({tag, ".overflow"}, bus.overflow, m_ovf);
        chk({tag, ".rd_data"}, bus.rd_data, m_rd);
        if (m_valid) begin
            chk({tag, ".addr"}, bus.cmd_addr, m_head.addr);
            chk({tag, ".data"}, bus.cmd_data, m_head.data);
            chk({tag, ".rw"}, bus.cmd_rw, m_head.rw);
            chk({tag, ".fc"}, bus.cmd_fc, m_head.fc);
            chk({tag, ".uds_n"}, bus.cmd_uds_n, m_head.uds_n);
            chk({tag, ".lds_n"}, bus.cmd_lds_n, m_head.lds_n);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, ".cmd_valid"}, bus.cmd_valid, 0);
        chk({tag, ".busy"}, bus.busy, 0);
        chk({tag, ".overflow"}, bus.overflow, 0);
        chk({tag, ".rd_data"}, bus.rd_data, 0);
        chk({tag, ".addr"}, bus.cmd_addr, 0);
        chk({tag, ".data"}, bus.cmd_data, 0);
        chk({tag, ".fc"}, bus.cmd_fc, 0);
        chk({tag, ".rw"}, bus.cmd_rw, 1);
        chk({tag, ".uds_n"}, bus.cmd_uds_n, 1);
        chk({tag, ".lds_n"}, bus.cmd_lds_n, 1);
    endtask

    // ---------------- driver ----------------
    // Called at a falling edge; returns at the next falling edge.
    task automatic cycle(input bit stb, input bit [1:0] rg, input bit [15:0] wd,
                         input bit rdy, input bit rsp, input bit [15:0] rdat);
        bus.wr_stb    = stb;
        bus.wr_reg    = rg;
        bus.wr_data   = wd;
        bus.cmd_ready = rdy;
        bus.rsp_valid = rsp;
        bus.rsp_data  = rdat;
        @(posedge clk);
        model_edge(stb, rg, wd, rdy, rsp, rdat);
        @(negedge clk);
    endtask

    task automatic cyc_chk(input string tag, input bit stb, input bit [1:0] rg,
                           input bit [15:0] wd, input bit rdy, input bit rsp);
        cycle(stb, rg, wd, rdy, rsp, 16'($urandom));
        check_model(tag);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((m_q.size() != 0 || m_out) && n < 200) begin
            cyc_chk(tag, 0, R_DATA, 16'h0, 1, m_out);
            n++;
        end
        cyc_chk(tag, 0, R_DATA, 16'h0, 0, 0);
        chk({tag, ".idle_busy"}, bus.busy, 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit        stb;
        bit [1:0]  rg;
        bit [15:0] wd;
        bit        rdy;
        bit        rsp;
        bit [15:0] rdat;
        bit        e_valid;
        bit [23:0] e_addr;
        bit [15:0] e_data;
        bit        e_rw;
        bit        e_uds;
        bit        e_lds;
        bit        e_busy;
        bit [15:0] e_rd;
    } vec_t;

    vec_t vt[12];

    initial begin
        bit [1:0] rg;
        int       r;

        vt[0]  = '{1, R_DATA, 16'h1234, 0, 0, 16'h0,    0, 24'h0, 16'h0, 0, 0, 0, 0, 16'h0};
        vt[1]  = '{1, R_LO,   16'h5678, 0, 0, 16'h0,    0, 24'h0, 16'h0, 0, 0, 0, 0, 16'h0};
        vt[2]  = '{1, R_HI,   16'h0012, 0, 0, 16'h0,    0, 24'h0, 16'h0, 0, 0, 0, !POSTED, 16'h0};
        vt[3]  = '{0, R_DATA, 16'h0,    0, 0, 16'h0,    1, 24'h125678, 16'h1234, 0, 0, 0, !POSTED, 16'h0};
        vt[4]  = '{0, R_DATA, 16'h0,    1, 0, 16'h0,    0, 24'h0, 16'h0, 0, 0, 0, !POSTED, 16'h0};
        vt[5]  = '{0, R_DATA, 16'h0,    0, 1, 16'hBEEF, 0, 24'h0, 16'h0, 0, 0, 0, 0, 16'h0};
        vt[6]  = '{1, R_LO,   16'h0001, 0, 0, 16'h0,    0, 24'h0, 16'h0, 0, 0, 0, 0, 16'h0};
        vt[7]  = '{1, R_HI,   16'h0300, 0, 0, 16'h0,    0, 24'h0, 16'h0, 0, 0, 0, 1, 16'h0};
        vt[8]  = '{0, R_DATA, 16'h0,    0, 0, 16'h0,    1, 24'h000001, 16'h1234, 1, 1, 0, 1, 16'h0};
        vt[9]  = '{0, R_DATA, 16'h0,    1, 0, 16'h0,    0, 24'h0, 16'h0, 0, 0, 0, 1, 16'h0};
        vt[10] = '{0, R_DATA, 16'h0,    0, 1, 16'h00AB, 0, 24'h0, 16'h0, 0, 0, 0, 0, 16'h00AB};
        vt[11] = '{0, R_DATA, 16'h0,    0, 0, 16'h0,    0, 24'h0, 16'h0, 0, 0, 0, 0, 16'h00AB};

        // ---- reset ----
        rst_n         = 1'b0;
        bus.wr_stb    = 0;
        bus.wr_reg    = 0;
        bus.wr_data   = 0;
        bus.cmd_ready = 0;
        bus.rsp_valid = 0;
        bus.rsp_data  = 0;
        model_reset();
        repeat (3) @(negedge clk);
        chk_reset_values("reset");
        rst_n = 1'b1;
        cyc_chk("post_reset", 0, R_DATA, 16'h0, 0, 0);

        // ---- directed table: word write then byte read ----
        for (int i = 0; i < 12; i++) begin
            string tag;
            cycle(vt[i].stb, vt[i].rg, vt[i].wd, vt[i].rdy, vt[i].rsp, vt[i].rdat);
            tag = $sformatf("vec%0d", i);
            chk({tag, ".cmd_valid"}, bus.cmd_valid, vt[i].e_valid);
            chk({tag, ".busy"}, bus.busy, vt[i].e_busy);
            chk({tag, ".overflow"}, bus.overflow, 0);
            chk({tag, ".rd_data"}, bus.rd_data, vt[i].e_rd);
            if (vt[i].e_valid) begin
                chk({tag, ".addr"}, bus.cmd_addr, vt[i].e_addr);
                chk({tag, ".data"}, bus.cmd_data, vt[i].e_data);
                chk({tag, ".rw"}, bus.cmd_rw, vt[i].e_rw);
                chk({tag, ".uds_n"}, bus.cmd_uds_n, vt[i].e_uds);
                chk({tag, ".lds_n"}, bus.cmd_lds_n, vt[i].e_lds);
            end
        end

        // ---- fill past capacity with the engine stalled ----
        cyc_chk("fill", 1, R_DATA, 16'hA5A5, 0, 0);
        cyc_chk("fill", 1, R_LO, 16'h0010, 0, 0);
        for (int k = 0; k < CAP; k++) begin
            cyc_chk("fill", 1, R_HI, 16'h0020 | 16'(k), 0, 0);
        end
        chk("fill.busy_at_cap", bus.busy, 1);
        chk("fill.no_ovf_at_cap", bus.overflow, 0);
        cyc_chk("fill", 1, R_HI, 16'h002F, 0, 0);
        chk("fill.ovf_dropped", bus.overflow, 1);
        cyc_chk("ovf_keep", 1, R_ST, 16'h7FFF, 0, 0);
        chk("ovf_keep", bus.overflow, 1);
        cyc_chk("ovf_clear", 1, R_ST, 16'h8000, 0, 0);
        chk("ovf_clear", bus.overflow, 0);
        drain("fill_drain");

        // ---- commit together with a pop: full, then one below full ----
        for (int k = 0; k < CAP; k++) begin
            cyc_chk("simul", 1, R_HI, 16'h0030 | 16'(k), 0, 0);
        end
        cyc_chk("simul", 0, R_DATA, 16'h0, 0, 0);
        chk("simul.valid_when_full", bus.cmd_valid, 1);
        cyc_chk("simul_full", 1, R_HI, 16'h003E, 1, 0);
        chk("simul_full.ovf", bus.overflow, 1);
        cyc_chk("simul", 1, R_ST, 16'h8000, 0, 0);
        cyc_chk("simul", 0, R_DATA, 16'h0, 0, 1);
        cyc_chk("simul", 0, R_DATA, 16'h0, 0, 0);
        cyc_chk("simul_below", 1, R_HI, 16'h003F, 1, 0);
        chk("simul_below.ovf", bus.overflow, 0);
        drain("simul_drain");

        // ---- randomized traffic ----
        for (int c = 0; c < 2500; c++) begin
            r = $urandom_range(0, 9);
            rg = (r < 3) ? R_DATA : (r < 6) ? R_LO : (r < 9) ? R_HI : R_ST;
            cyc_chk("rand", ($urandom_range(0, 2) == 0), rg, 16'($urandom),
                    1'($urandom_range(0, 1)),
                    m_out ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0));
        end
        drain("rand_drain");

        // ---- reset with work queued and a cycle in flight ----
        for (int k = 0; k <= CAP; k++) begin
            cyc_chk("pre_rst", 1, R_HI, 16'h0240 | 16'(k), 0, 0);
        end
        cyc_chk("pre_rst", 0, R_DATA, 16'h0, 1, 0);
        #2 rst_n = 1'b0;
        #1 model_reset();
        chk_reset_values("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        cyc_chk("stray_rsp", 0, R_DATA, 16'h0, 0, 1);
        chk("stray_rsp.busy", bus.busy, 0);
        chk("stray_rsp.rd_data", bus.rd_data, 0);
        chk("stray_rsp.valid", bus.cmd_valid, 0);
        cyc_chk("after_rst", 0, R_DATA, 16'h0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
